// File: rtl/p4_pipe_adder.sv
// Pipelined add/subtract unit with carry, signed-overflow and zero flags,
// stall-all valid/ready flow control and a saturating completed-result counter.
module p4_pipe_adder #(
    parameter int DWIDTH = 32,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    input  logic              cin,
    input  logic              sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] sum,
    output logic              cout,
    output logic              ovf,
    output logic              zero,
    output logic [CNT_W-1:0]  op_count
);

    // Handshake: a beat moves on a clock edge only when its valid and the
    // receiver's ready are both high; ready never depends on the sender's valid.
    logic advance;

    logic [DWIDTH-1:0] b_eff;
    logic              c_eff;
    logic [DWIDTH:0]   full;
    logic              ovf_calc;

    logic [STAGES-1:0] valid_q;
    logic [DWIDTH-1:0] sum_q [STAGES];
    logic [STAGES-1:0] cout_q;
    logic [STAGES-1:0] ovf_q;
    logic [STAGES-1:0] zero_q;
    logic [CNT_W-1:0]  count_q;

    // The whole pipe stalls together, so an empty output slot or a taking
    // consumer is enough to let every slot move.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    assign b_eff    = sub ? ~b : b;
    assign c_eff    = cin ^ sub;
    assign full     = {1'b0, a} + {1'b0, b_eff} + {{DWIDTH{1'b0}}, c_eff};
    assign ovf_calc = (a[DWIDTH-1] == b_eff[DWIDTH-1]) && (full[DWIDTH-1] != a[DWIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            cout_q  <= '0;
            ovf_q   <= '0;
            zero_q  <= '0;
            for (int i = 0; i < STAGES; i++) begin
                sum_q[i] <= '0;
            end
        end else if (advance) begin
            valid_q[0] <= in_valid;
            sum_q[0]   <= full[DWIDTH-1:0];
            cout_q[0]  <= full[DWIDTH];
            ovf_q[0]   <= ovf_calc;
            zero_q[0]  <= (full[DWIDTH-1:0] == '0);
            for (int i = 1; i < STAGES; i++) begin
                valid_q[i] <= valid_q[i-1];
                sum_q[i]   <= sum_q[i-1];
                cout_q[i]  <= cout_q[i-1];
                ovf_q[i]   <= ovf_q[i-1];
                zero_q[i]  <= zero_q[i-1];
            end
        end
    end

    // Counts result transfers and sticks at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (out_valid && out_ready && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = cout_q[STAGES-1];
    assign ovf       = ovf_q[STAGES-1];
    assign zero      = zero_q[STAGES-1];
    assign op_count  = count_q;

endmodule

// File: tb/tb_p4_pipe_adder.sv
// Directed bench for p4_pipe_adder: a 32-bit two-stage instance for arithmetic,
// flow control and reset, plus an 8-bit single-stage instance with a 2-bit counter.
module tb_p4_pipe_adder;

    localparam int LAT1 = 1;  // STAGES-1 edges after acceptance for the main instance

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready;
    logic [31:0] a, b, sum;
    logic        cout, ovf, zero;
    logic [15:0] op_count;

    logic        in_valid2, in_ready2, cin2, sub2, out_valid2, out_ready2;
    logic [7:0]  a2, b2, sum2;
    logic        cout2, ovf2, zero2;
    logic [1:0]  op_count2;

    int n_cmp = 0;
    int n_bad = 0;

    p4_pipe_adder #(.DWIDTH(32), .STAGES(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero),
        .op_count(op_count)
    );

    p4_pipe_adder #(.DWIDTH(8), .STAGES(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .cin(cin2), .sub(sub2), .out_valid(out_valid2),
        .out_ready(out_ready2), .sum(sum2), .cout(cout2), .ovf(ovf2), .zero(zero2),
        .op_count(op_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        z;
    } vec_t;

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0;
        out_ready = 1'b1; out_ready2 = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (op_count !== 16'd0) begin n_bad++; $display("FAIL reset_op_count: got %0d want 0", op_count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if ({sum, cout, ovf, zero} !== 35'd0) begin n_bad++; $display("FAIL reset_data: got sum=%h c=%b o=%b z=%b want 0", sum, cout, ovf, zero); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            n_cmp++; if (out_valid !== 1'b0 || sum !== 32'd0) begin n_bad++; $display("FAIL idle_%0d: got valid=%b sum=%h want 0/0", i, out_valid, sum); end
        end
    endtask

    task automatic test_arith();
        vec_t vecs[7];
        int   lat;
        vecs[0] = '{a: 32'hFFFF_FFFF, b: 32'd1, cin: 1'b0, sub: 1'b0, s: 32'h0000_0000, c: 1'b1, o: 1'b0, z: 1'b1};
        vecs[1] = '{a: 32'd5,         b: 32'd7, cin: 1'b0, sub: 1'b1, s: 32'hFFFF_FFFE, c: 1'b0, o: 1'b0, z: 1'b0};
        vecs[2] = '{a: 32'h7FFF_FFFF, b: 32'd1, cin: 1'b0, sub: 1'b0, s: 32'h8000_0000, c: 1'b0, o: 1'b1, z: 1'b0};
        vecs[3] = '{a: 32'h8000_0000, b: 32'd1, cin: 1'b0, sub: 1'b1, s: 32'h7FFF_FFFF, c: 1'b1, o: 1'b1, z: 1'b0};
        vecs[4] = '{a: 32'd10,        b: 32'd3, cin: 1'b1, sub: 1'b1, s: 32'd6,         c: 1'b1, o: 1'b0, z: 1'b0};
        vecs[5] = '{a: 32'd1,         b: 32'd2, cin: 1'b1, sub: 1'b0, s: 32'd4,         c: 1'b0, o: 1'b0, z: 1'b0};
        vecs[6] = '{a: 32'd9,         b: 32'd9, cin: 1'b0, sub: 1'b1, s: 32'd0,         c: 1'b1, o: 1'b0, z: 1'b1};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; sub = vecs[i].sub; out_ready = 1'b1;
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL arith%0d_in_ready: got %b want 1", i, in_ready); end
            @(posedge clk); @(negedge clk);
            in_valid = 1'b0;
            lat = 0;
            while (out_valid !== 1'b1 && lat < 20) begin
                @(posedge clk); @(negedge clk);
                lat++;
            end
            n_cmp++; if (lat != LAT1) begin n_bad++; $display("FAIL arith%0d_latency: got %0d want %0d", i, lat, LAT1); end
            n_cmp++; if (sum !== vecs[i].s) begin n_bad++; $display("FAIL arith%0d_sum: got %h want %h", i, sum, vecs[i].s); end
            n_cmp++; if ({cout, ovf, zero} !== {vecs[i].c, vecs[i].o, vecs[i].z}) begin n_bad++; $display("FAIL arith%0d_flags: got c%b o%b z%b want c%b o%b z%b", i, cout, ovf, zero, vecs[i].c, vecs[i].o, vecs[i].z); end
            n_cmp++; if (op_count !== 16'(i)) begin n_bad++; $display("FAIL arith%0d_count_before: got %0d want %0d", i, op_count, i); end
            @(posedge clk); @(negedge clk);
            n_cmp++; if (op_count !== 16'(i + 1) || out_valid !== 1'b0) begin n_bad++; $display("FAIL arith%0d_count_after: got %0d valid=%b want %0d valid=0", i, op_count, out_valid, i + 1); end
        end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        int r = 0;
        int c = 0;
        do_reset(1);
        while (r < 6 && c < 40) begin
            out_ready = !(c >= 3 && c < 6);
            in_valid  = (k < 6);
            a = 32'(k + 1); b = 32'd10; cin = 1'b0; sub = 1'b0;
            #1;
            if (c >= 3 && c < 6) begin
                n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready_c%0d: got %b want 0", c, in_ready); end
                n_cmp++; if (out_valid !== 1'b1 || sum !== 32'(11 + r)) begin n_bad++; $display("FAIL stall_hold_c%0d: got valid=%b sum=%0d want 1/%0d", c, out_valid, sum, 11 + r); end
            end
            if (out_valid && out_ready) begin
                n_cmp++; if (sum !== 32'(11 + r)) begin n_bad++; $display("FAIL bp_result%0d: got %0d want %0d", r, sum, 11 + r); end
                r++;
            end
            if (in_valid && in_ready) k++;
            @(posedge clk); @(negedge clk);
            c++;
        end
        in_valid = 1'b0;
        n_cmp++; if (r != 6 || k != 6) begin n_bad++; $display("FAIL bp_complete: got %0d results %0d accepted want 6/6", r, k); end
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_extra%0d: got valid=%b want 0", i, out_valid); end
            @(posedge clk); @(negedge clk);
        end
        n_cmp++; if (op_count !== 16'd6) begin n_bad++; $display("FAIL bp_count: got %0d want 6", op_count); end
    endtask

    task automatic test_reset_midstream();
        int lat;
        @(negedge clk);
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1; a = 32'(20 + j); b = 32'd0; cin = 1'b0; sub = 1'b0;
            @(posedge clk); @(negedge clk);
        end
        rst = 1'b1; in_valid = 1'b1; a = 32'd100;
        @(posedge clk); @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_flush%0d: got valid=%b want 0", i, out_valid); end
            @(posedge clk); @(negedge clk);
        end
        n_cmp++; if (op_count !== 16'd0) begin n_bad++; $display("FAIL mid_rst_count: got %0d want 0", op_count); end
        in_valid = 1'b1; a = 32'd2; b = 32'd3; cin = 1'b0; sub = 1'b0;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        n_cmp++; if (lat != LAT1 || sum !== 32'd5) begin n_bad++; $display("FAIL mid_rst_next: got lat=%0d sum=%0d want lat=%0d sum=5", lat, sum, LAT1); end
        @(posedge clk); @(negedge clk);
        n_cmp++; if (op_count !== 16'd1) begin n_bad++; $display("FAIL mid_rst_next_count: got %0d want 1", op_count); end
    endtask

    task automatic test_saturation();
        int exp_seq[5];
        int k = 0;
        int r = 0;
        int c = 0;
        bit xfer = 1'b0;
        exp_seq = '{1, 2, 3, 3, 3};
        do_reset(1);
        cin2 = 1'b0; sub2 = 1'b0;
        while ((r < 5 || xfer) && c < 30) begin
            if (xfer) begin
                n_cmp++; if (op_count2 !== 2'(exp_seq[r-1])) begin n_bad++; $display("FAIL sat_count%0d: got %0d want %0d", r - 1, op_count2, exp_seq[r-1]); end
                xfer = 1'b0;
            end
            in_valid2 = (k < 5); a2 = 8'(k); b2 = 8'd1; out_ready2 = 1'b1;
            #1;
            if (out_valid2 && out_ready2) begin
                n_cmp++; if ({sum2, cout2, ovf2, zero2} !== {8'(r + 1), 3'b000}) begin n_bad++; $display("FAIL sat_result%0d: got sum=%0d c%b o%b z%b want %0d c0 o0 z0", r, sum2, cout2, ovf2, zero2, r + 1); end
                r++;
                xfer = 1'b1;
            end
            if (in_valid2 && in_ready2) k++;
            @(posedge clk); @(negedge clk);
            c++;
        end
        in_valid2 = 1'b0;
        n_cmp++; if (r != 5) begin n_bad++; $display("FAIL sat_complete: got %0d results want 5", r); end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; sub2 = 1'b0; out_ready2 = 1'b1;
        test_reset();
        test_arith();
        test_back_to_back();
        test_reset_midstream();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/p4_pipe_adder.md
# p4_pipe_adder

Parametrised, pipelined successor to the combinational P4 adder datapath: a DWIDTH-bit add/subtract unit with a configurable number of register stages and valid/ready handshakes on both sides. It also provides carry, signed-overflow and zero flags, plus a saturating count of completed operations. It sits between the stimulus/driver side and the checker, replacing the ad-hoc "sample Scomb on clk edge" synchronisation with a defined, back-pressurable latency.

## Interface
- DWIDTH, 32, operand/result width (>= 2)
- STAGES, 2, pipeline depth in cycles (>= 1)
- CNT_W, 16, width of the completed-operation counter (>= 1)

- clk  in  1  single clock, all logic on posedge
- rst  in  1  reset, synchronous and active-high
- in_valid  in  1  operand beat valid
- in_ready  out  1  unit accepts a beat this cycle
- a  in  DWIDTH  operand A
- b  in  DWIDTH  operand B
- cin  in  1  carry-in (borrow-in when sub=1)
- sub  in  1  0 = add, 1 = subtract
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- sum  out  DWIDTH  result
- cout  out  1  carry-out of the DWIDTH-bit addition
- ovf  out  1  signed (two's complement) overflow
- zero  out  1  sum == 0
- op_count  out  CNT_W  completed results, saturating

## Operation
- Arithmetic is evaluated on the accepted input beat: b_eff = sub ? ~b : b; c_eff = cin ^ sub; {cout, sum} = a + b_eff + c_eff, computed at DWIDTH+1 bits.
  - sub=1, cin=0 gives a-b; sub=1, cin=1 gives a-b-1.
  - For subtraction, cout=1 means no borrow.
- ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
- zero = (sum == 0), evaluated on the DWIDTH-bit sum only (cout excluded).
- Result and flags travel through STAGES register slots, each holding {valid, sum, cout, ovf, zero}. The last slot drives the outputs.
- Stall-all flow control:
  - advance = !out_valid || out_ready.
  - in_ready = advance, combinational and independent of in_valid.
  - When advance=1, every slot shifts one place and slot 0 loads {in_valid, result}.
  - When advance=0, all slots hold.
- A beat is accepted iff in_valid && in_ready. A result transfers iff out_valid && out_ready.
- Bubbles (invalid slots) are not collapsed. Order is strictly preserved, and no beat is dropped or duplicated.
- op_count increments by 1 on each result transfer and holds at 2^CNT_W-1 (no wrap).
- Data and flag outputs while out_valid=0 are don't-care for checkers; the implementation clears them at reset only.

## Timing
- Reset: on any posedge with rst=1, all slot valids, sums, flags and op_count go to 0.
  - Outputs after reset: out_valid=0, sum=0, cout=0, ovf=0, zero=0, op_count=0, in_ready=1.
  - Reset mid-stream discards all in-flight beats; no result is presented for them.
  - Input presented during a reset cycle is not accepted.
- Latency: a beat accepted at edge N (with no stall afterwards) appears with out_valid=1 after edge N+STAGES-1, i.e. it is transferable at edge N+STAGES.
  - STAGES=1: result visible the cycle after acceptance.
- Throughput: 1 beat/cycle while out_ready=1.
- Simultaneous transfer-out and accept in the same cycle is legal and required for full throughput.
- Once out_valid=1, sum/cout/ovf/zero stay stable until the transfer edge.
- in_valid may toggle freely; no requirement that it hold while in_ready=0 (a beat is simply not taken).

## Test plan
- Reset then idle: after rst held 2 cycles -> out_valid=0, op_count=0, in_ready=1; outputs stay 0 with in_valid=0 for 10 cycles.
- Add wrap (DWIDTH=32, STAGES=2): a=FFFF_FFFF, b=1, cin=0, sub=0 -> 2 cycles later sum=0, cout=1, zero=1, ovf=0; op_count=1 after transfer.
- Subtract and overflow:
  - a=5, b=7, sub=1, cin=0 -> sum=FFFF_FFFE, cout=0, ovf=0.
  - a=7FFF_FFFF, b=1, sub=0 -> sum=8000_0000, ovf=1.
  - a=8000_0000, b=1, sub=1 -> sum=7FFF_FFFF, ovf=1, cout=1.
- Backpressure: stream 6 beats (a=1..6, b=10) with out_ready low for 3 cycles mid-stream -> in_ready=0 during the stall, results 11..16 in order, none lost or duplicated, op_count=6.
- Reset mid-stream: 3 beats in flight, assert rst 1 cycle -> no results emerge, op_count=0; next beat a=2, b=3 returns 5 after STAGES cycles.
- Counter saturation (CNT_W=2, STAGES=1): 5 back-to-back transfers -> op_count sequence 1, 2, 3, 3, 3.
